// File: rtl/stopwatch_pkg.sv
// Shared types and default timing constants for the stopwatch control path
// and the digit counter chain.
package stopwatch_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RUNNING = 2'd1,
    PAUSED  = 2'd2
  } sw_state_t;

  localparam int unsigned DEFAULT_TICK_DIVISOR    = 1_000_000;
  localparam int unsigned DEFAULT_DEBOUNCE_CYCLES = 500_000;

  // Counter width that can hold 0..n-1, never narrower than one bit.
  function automatic int unsigned cnt_width(input int unsigned n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/stopwatch_timebase_debouncer.sv
// Raw button conditioning: two-flop synchronizer, stable-level debounce and a
// registered one-cycle pulse on each accepted press.
module button_debouncer
  import stopwatch_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn_raw,
  output logic press
);

  localparam int unsigned      CW       = cnt_width(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0]    CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);
  localparam logic [CW-1:0]    CNT_ONE  = CW'(1);

  logic          sync1_q, sync1_d;
  logic          sync2_q, sync2_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          level_q, level_d;
  logic          level_dly_q, level_dly_d;
  logic          press_q, press_d;

  always_comb begin
    sync1_d     = btn_raw;
    sync2_d     = sync1_q;
    cnt_d       = cnt_q;
    level_d     = level_q;
    level_dly_d = level_q;
    press_d     = level_q & ~level_dly_q;

    // The counter only runs while the synchronized level disagrees with the
    // accepted level; any agreement restarts the window.
    if (sync2_q == level_q) begin
      cnt_d = '0;
    end else if (cnt_q == CNT_LAST) begin
      level_d = sync2_q;
      cnt_d   = '0;
    end else begin
      cnt_d = cnt_q + CNT_ONE;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q     <= 1'b0;
      sync2_q     <= 1'b0;
      cnt_q       <= '0;
      level_q     <= 1'b0;
      level_dly_q <= 1'b0;
      press_q     <= 1'b0;
    end else begin
      sync1_q     <= sync1_d;
      sync2_q     <= sync2_d;
      cnt_q       <= cnt_d;
      level_q     <= level_d;
      level_dly_q <= level_dly_d;
      press_q     <= press_d;
    end
  end

  assign press = press_q;

endmodule

// File: rtl/stopwatch_timebase.sv
// Stopwatch control: run/pause/idle FSM driven by two debounced buttons, and
// the prescaler producing the increment strobe for the digit counter chain.
module stopwatch_timebase
  import stopwatch_pkg::*;
#(
  parameter int unsigned TICK_DIVISOR    = DEFAULT_TICK_DIVISOR,
  parameter int unsigned DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES
) (
  input  logic clk,
  input  logic reset,
  input  logic btn_start_stop,
  input  logic btn_clear,
  output logic increment,
  output logic clear,
  output logic running,
  output logic paused
);

  localparam int unsigned   PW         = $clog2(TICK_DIVISOR);
  localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIVISOR - 1);
  localparam logic [PW-1:0] PRESC_ONE  = PW'(1);

  logic          ss_ev;
  logic          clr_ev;
  sw_state_t     state_q, state_d;
  logic [PW-1:0] presc_q, presc_d;
  logic          inc_q, inc_d;
  logic          clr_q, clr_d;

  button_debouncer #(
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
  ) u_db_start_stop (
    .clk     (clk),
    .rst_n   (reset),
    .btn_raw (btn_start_stop),
    .press   (ss_ev)
  );

  button_debouncer #(
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
  ) u_db_clear (
    .clk     (clk),
    .rst_n   (reset),
    .btn_raw (btn_clear),
    .press   (clr_ev)
  );

  always_comb begin
    state_d = state_q;
    presc_d = presc_q;
    inc_d   = 1'b0;
    clr_d   = 1'b0;

    if (clr_ev) begin
      state_d = IDLE;
      presc_d = '0;
      clr_d   = 1'b1;
    end else begin
      unique case (state_q)
        IDLE: begin
          presc_d = '0;
          if (ss_ev) state_d = RUNNING;
        end
        RUNNING: begin
          // On a pause event the prescaler holds, so the partial tick survives
          // and no strobe can escape on the transition cycle.
          if (ss_ev) begin
            state_d = PAUSED;
          end else if (presc_q == PRESC_LAST) begin
            presc_d = '0;
            inc_d   = 1'b1;
          end else begin
            presc_d = presc_q + PRESC_ONE;
          end
        end
        PAUSED: begin
          if (ss_ev) state_d = RUNNING;
        end
        default: begin
          state_d = IDLE;
          presc_d = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      presc_q <= '0;
      inc_q   <= 1'b0;
      clr_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      presc_q <= presc_d;
      inc_q   <= inc_d;
      clr_q   <= clr_d;
    end
  end

  assign increment = inc_q;
  assign clear     = clr_q;
  assign running   = (state_q == RUNNING);
  assign paused    = (state_q == PAUSED);

endmodule

// File: tb/tb_stopwatch_timebase.sv
// Directed bench for stopwatch_timebase with TICK_DIVISOR=4, DEBOUNCE_CYCLES=3.
// Cycle c is the clock period that begins at rising edge c.
module tb_stopwatch_timebase;
  import stopwatch_pkg::*;

  logic clk = 1'b0;
  logic reset;
  logic btn_start_stop;
  logic btn_clear;
  logic increment;
  logic clear;
  logic running;
  logic paused;

  int checks    = 0;
  int errors    = 0;
  int cyc       = 0;
  int t0        = 0;
  int inc_count = 0;

  stopwatch_timebase #(
    .TICK_DIVISOR    (4),
    .DEBOUNCE_CYCLES (3)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .btn_start_stop (btn_start_stop),
    .btn_clear      (btn_clear),
    .increment      (increment),
    .clear          (clear),
    .running        (running),
    .paused         (paused)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (reset === 1'b1 && increment === 1'b1) inc_count++;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s (cycle %0d): observed %0h expected %0h", tag, cyc - t0, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic goto(input int c);
    while (cyc < t0 + c) step();
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_inc"}, {31'd0, increment}, 32'd0);
    chk({tag, "_clr"}, {31'd0, clear},     32'd0);
    chk({tag, "_run"}, {31'd0, running},   32'd0);
    chk({tag, "_pau"}, {31'd0, paused},    32'd0);
  endtask

  initial begin
    reset          = 1'b0;
    btn_start_stop = 1'b0;
    btn_clear      = 1'b0;
    repeat (3) step();
    chk_all_zero("in_reset");
    reset = 1'b1;
    cyc   = 0;

    // Idle after reset
    goto(50);
    chk_all_zero("idle50");
    chk("idle50_state", 32'(dut.state_q), 32'(IDLE));
    chk("idle50_nticks", inc_count, 32'd0);
    t0 = cyc;

    // Start: press during cycle 10 -> running in cycle 17, ticks at 21, 25, ...
    goto(10);
    btn_start_stop = 1'b1;
    goto(16);
    chk("start_early_run", {31'd0, running}, 32'd0);
    for (int c = 17; c <= 31; c++) begin
      goto(c);
      chk("run1_run", {31'd0, running}, 32'd1);
      chk("run1_inc", {31'd0, increment}, 32'((c >= 21) && ((c - 21) % 4 == 0)));
    end
    btn_start_stop = 1'b0;

    // Two-cycle glitch is ignored; held press from cycle 49 pauses in cycle 56
    for (int c = 32; c <= 55; c++) begin
      goto(c);
      chk("run2_run", {31'd0, running}, 32'd1);
      chk("run2_inc", {31'd0, increment}, 32'((c - 21) % 4 == 0));
      if (c == 40) btn_start_stop = 1'b1;
      if (c == 42) btn_start_stop = 1'b0;
      if (c == 49) btn_start_stop = 1'b1;
    end
    for (int c = 56; c <= 77; c++) begin
      goto(c);
      chk("pause_pau", {31'd0, paused}, 32'd1);
      chk("pause_run", {31'd0, running}, 32'd0);
      chk("pause_inc", {31'd0, increment}, 32'd0);
      if (c == 59) btn_start_stop = 1'b0;
    end
    chk("pause_presc", 32'(dut.presc_q), 32'd2);

    // Resume with prescaler 2: running in 85, first tick 87, then every 4
    goto(78);
    btn_start_stop = 1'b1;
    goto(82);
    btn_start_stop = 1'b0;
    goto(84);
    chk("resume_wait_pau", {31'd0, paused}, 32'd1);
    for (int c = 85; c <= 105; c++) begin
      goto(c);
      chk("run3_run", {31'd0, running}, 32'd1);
      chk("run3_inc", {31'd0, increment}, 32'((c >= 87) && ((c - 87) % 4 == 0)));
      if (c == 100) begin
        btn_start_stop = 1'b1;
        btn_clear      = 1'b1;
      end
    end

    // Both events land in cycle 106 with prescaler at 3: clear wins, no tick
    goto(106);
    btn_start_stop = 1'b0;
    btn_clear      = 1'b0;
    chk("both_evt_run", {31'd0, running}, 32'd1);
    chk("both_evt_inc", {31'd0, increment}, 32'd0);
    for (int c = 107; c <= 120; c++) begin
      goto(c);
      chk("clr_clr", {31'd0, clear}, 32'(c == 107));
      chk("clr_run", {31'd0, running}, 32'd0);
      chk("clr_pau", {31'd0, paused}, 32'd0);
      chk("clr_inc", {31'd0, increment}, 32'd0);
    end
    chk("clr_state", 32'(dut.state_q), 32'(IDLE));

    // Restart, then reset for one cycle at prescaler 3 (cycle 144)
    for (int c = 121; c <= 144; c++) begin
      goto(c);
      chk("run4_run", {31'd0, running}, 32'(c >= 137));
      chk("run4_inc", {31'd0, increment}, 32'(c == 141));
      if (c == 130) btn_start_stop = 1'b1;
      if (c == 136) btn_start_stop = 1'b0;
    end
    chk("prereset_presc", 32'(dut.presc_q), 32'd3);
    reset = 1'b0;
    #1;
    chk_all_zero("reset_async");
    step();
    reset = 1'b1;
    chk_all_zero("reset_edge");
    for (int c = 146; c <= 150; c++) begin
      goto(c);
      chk_all_zero("post_reset");
      chk("post_reset_state", 32'(dut.state_q), 32'(IDLE));
    end

    chk("total_ticks", inc_count, 32'd15);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
